// File: rtl/reg_write_arbiter.sv
// Arbitrates two writeback sources onto the single register-file write port (1-cycle registered write).
// Ready is combinational and goes to at most one valid port per cycle; the loser simply waits.
module reg_write_arbiter #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int RR    = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_addr,
    input  logic [XLEN-1:0]  a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_addr,
    input  logic [XLEN-1:0]  b_data,
    input  logic [AW-1:0]    q1_addr,
    input  logic [AW-1:0]    q2_addr,
    output logic             hazard1,
    output logic             hazard2,
    output logic             write_en,
    output logic [AW-1:0]    write_addr,
    output logic [XLEN-1:0]  write_value,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic            rr_ptr;   // 0 = A goes next on a conflict, 1 = B
    logic            both;
    logic            grant_a;
    logic            grant_b;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    assign both = a_valid & b_valid;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (both) begin
                if (RR != 0) begin
                    grant_a = ~rr_ptr;
                    grant_b = rr_ptr;
                end else begin
                    grant_b = 1'b1;
                end
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign sel_addr = grant_b ? b_addr : a_addr;
    assign sel_data = grant_b ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            write_en    <= 1'b0;
            write_addr  <= '0;
            write_value <= '0;
            rr_ptr      <= 1'b0;
        end else begin
            // x0 writes are accepted but dropped; addr/value keep the last real write
            write_en <= (grant_a | grant_b) && (sel_addr != '0);
            if ((grant_a | grant_b) && (sel_addr != '0)) begin
                write_addr  <= sel_addr;
                write_value <= sel_data;
            end
            if (both && (RR != 0)) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (both && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    // A read hazards on anything requested or already on the write port, granted or not
    assign hazard1 = (q1_addr != '0) &&
                     ((a_valid && a_addr == q1_addr) ||
                      (b_valid && b_addr == q1_addr) ||
                      (write_en && write_addr == q1_addr));
    assign hazard2 = (q2_addr != '0) &&
                     ((a_valid && a_addr == q2_addr) ||
                      (b_valid && b_addr == q2_addr) ||
                      (write_en && write_addr == q2_addr));

endmodule
